ysyx_23060191_gpr_wb_arbiter: RTL

//  Single owner of the GPR write port (wr_en_Rd/addr_Rd/data_Rd).

---
 rtl/ysyx_23060191_gpr_wb_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/ysyx_23060191_gpr_wb_arbiter.sv
// GPR write-port owner: round-robin EXU/LSU write-back arbiter with a registered output stage
// and a per-register busy scoreboard used by IDU for RAW stalls.
module ysyx_23060191_gpr_wb_arbiter #(
    parameter int unsigned CPU_WIDTH = 32,
    parameter int unsigned NREG      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 exu_valid,
    output logic                 exu_ready,
    input  logic [4:0]           exu_rd,
    input  logic [CPU_WIDTH-1:0] exu_data,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [4:0]           lsu_rd,
    input  logic [CPU_WIDTH-1:0] lsu_data,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic [4:0]           query_rs1,
    input  logic [4:0]           query_rs2,
    output logic                 busy_rs1,
    output logic                 busy_rs2,
    output logic                 wr_en_Rd,
    output logic [4:0]           addr_Rd,
    output logic [CPU_WIDTH-1:0] data_Rd
);

    typedef enum logic {GrantExu, GrantLsu} grant_e;

    grant_e                last_grant_q;
    logic                  wr_en_q;
    logic [4:0]            addr_q;
    logic [CPU_WIDTH-1:0]  data_q;
    logic [NREG-1:0]       busy_q;
    logic [NREG-1:0]       busy_d;

    logic                  grant_exu;
    logic                  grant_lsu;
    logic                  granted;
    logic [4:0]            win_rd;
    logic [CPU_WIDTH-1:0]  win_data;

    // Ties go to whichever requester did not win last time.
    always_comb begin
        grant_exu = exu_valid && (!lsu_valid || (last_grant_q == GrantLsu));
        grant_lsu = lsu_valid && !grant_exu;
        granted   = grant_exu || grant_lsu;
        win_rd    = grant_exu ? exu_rd : lsu_rd;
        win_data  = grant_exu ? exu_data : lsu_data;
    end

    assign exu_ready = grant_exu;
    assign lsu_ready = grant_lsu;

    // Clear happens on the GPR write edge; a same-edge issue of the same rd re-sets it.
    always_comb begin
        busy_d   = busy_q;
        busy_rs1 = 1'b0;
        busy_rs2 = 1'b0;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (wr_en_q && (addr_q == 5'(r))) begin
                busy_d[r] = 1'b0;
            end
            if (issue_valid && (issue_rd == 5'(r))) begin
                busy_d[r] = 1'b1;
            end
            if (query_rs1 == 5'(r)) begin
                busy_rs1 = busy_q[r];
            end
            if (query_rs2 == 5'(r)) begin
                busy_rs2 = busy_q[r];
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GrantLsu;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            busy_q       <= '0;
        end else begin
            // x0 writes complete the handshake but never reach the GPR.
            wr_en_q <= granted && (win_rd != 5'd0);
            if (granted) begin
                addr_q       <= win_rd;
                data_q       <= win_data;
                last_grant_q <= grant_exu ? GrantExu : GrantLsu;
            end
            busy_q <= busy_d;
        end
    end

    assign wr_en_Rd = wr_en_q;
    assign addr_Rd  = addr_q;
    assign data_Rd  = data_q;

endmodule
